// File: rtl/alu_arbiter_if.sv
// Request/response channel pair for one alu_arbiter client port.
// The arbiter takes the slave side; the issuing client takes the master side.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [SEL_W-1:0]  req_sel;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_sel, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_sel, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one 32-bit Alu: IDLE (grant) -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

// 32-bit Alu, sel = {funct7[5], funct3}; undefined codes yield 0.
module alu (
    input  logic [3:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        case (sel)
            4'b0000: y = a + b;
            4'b1000: y = a - b;
            4'b0001: y = a << b[4:0];
            4'b0010: y = 32'($signed(a) < $signed(b));
            4'b0011: y = 32'(a < b);
            4'b0100: y = a ^ b;
            4'b0101: y = a >> b[4:0];
            4'b1101: y = $signed(a) >>> b[4:0];
            4'b0110: y = a | b;
            4'b0111: y = a & b;
            default: y = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave port0,
    alu_arbiter_if.slave port1
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_SLL = SEL_W'(4'b0001);
    localparam logic [SEL_W-1:0] SEL_SRL = SEL_W'(4'b0101);
    localparam logic [SEL_W-1:0] SEL_SRA = SEL_W'(4'b1101);

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic [SEL_W-1:0]  op_sel;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic              rsp0_valid;
    logic              rsp1_valid;

    logic              any_req_c;
    logic              grant_c;
    logic [SEL_W-1:0]  sel_c;
    logic [DATA_W-1:0] a_c;
    logic [DATA_W-1:0] b_raw_c;
    logic [DATA_W-1:0] b_c;
    logic              is_shift_c;
    logic              rsp_ready_c;
    logic [DATA_W-1:0] alu_y_c;

    // Arbitration: grant_c is the winning port index when any request is valid.
    always_comb begin
        any_req_c = port0.req_valid | port1.req_valid;
`ifdef ALU_ARB_RR_EN
        if (port0.req_valid && port1.req_valid) begin
            grant_c = ~last_grant;
        end else begin
            grant_c = ~port0.req_valid;
        end
`else
        grant_c = ~port0.req_valid;
`endif
    end

    // Winning payload; shift amounts keep only the low five bits of b.
    always_comb begin
        sel_c      = grant_c ? port1.req_sel : port0.req_sel;
        a_c        = grant_c ? port1.req_a   : port0.req_a;
        b_raw_c    = grant_c ? port1.req_b   : port0.req_b;
        is_shift_c = (sel_c == SEL_SLL) || (sel_c == SEL_SRL) || (sel_c == SEL_SRA);
        b_c        = is_shift_c ? DATA_W'(b_raw_c[4:0]) : b_raw_c;
        rsp_ready_c = owner ? port1.rsp_ready : port0.rsp_ready;
    end

    alu u_alu (
        .sel (op_sel),
        .a   (op_a),
        .b   (op_b),
        .y   (alu_y_c)
    );

    assign port0.req_ready = rst_n && (state == IDLE) && any_req_c && !grant_c;
    assign port1.req_ready = rst_n && (state == IDLE) && any_req_c &&  grant_c;
    assign port0.rsp_valid = rsp0_valid;
    assign port1.rsp_valid = rsp1_valid;
    assign port0.rsp_data  = result;
    assign port1.rsp_data  = result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_sel     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        op_sel     <= sel_c;
                        op_a       <= a_c;
                        op_b       <= b_c;
                        owner      <= grant_c;
                        last_grant <= grant_c;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result     <= alu_y_c;
                    rsp0_valid <= ~owner;
                    rsp1_valid <=  owner;
                    state      <= RESP;
                end
                RESP: begin
                    // Response held until the owning port consumes it.
                    if (rsp_ready_c) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // While an op is in flight its owner is always the most recent grant.
    a_owner_is_last_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (state != IDLE) |-> (owner == last_grant));

    a_ready_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(port0.req_ready && port1.req_ready));
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases plus randomized traffic,
// checked against a behavioural Alu/arbitration model.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        rv[2];
    logic [3:0]  rsel[2];
    logic [31:0] ra[2];
    logic [31:0] rb[2];
    logic        rrdy[2];
    logic        hold[2];
    logic        rnd_ready;
    logic        ready[2];
    logic        rspv[2];
    logic [31:0] rspd[2];

    alu_arbiter_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) p0_if ();
    alu_arbiter_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) p1_if ();

    assign p0_if.req_valid = rv[0];
    assign p0_if.req_sel   = rsel[0];
    assign p0_if.req_a     = ra[0];
    assign p0_if.req_b     = rb[0];
    assign p0_if.rsp_ready = rrdy[0];
    assign p1_if.req_valid = rv[1];
    assign p1_if.req_sel   = rsel[1];
    assign p1_if.req_a     = ra[1];
    assign p1_if.req_b     = rb[1];
    assign p1_if.rsp_ready = rrdy[1];
    assign ready[0] = p0_if.req_ready;
    assign ready[1] = p1_if.req_ready;
    assign rspv[0]  = p0_if.rsp_valid;
    assign rspv[1]  = p1_if.rsp_valid;
    assign rspd[0]  = p0_if.rsp_data;
    assign rspd[1]  = p1_if.rsp_data;

    alu_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port0 (p0_if),
        .port1 (p1_if)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   mdl_last = 1;
    logic seen[2];
    logic [31:0] held[2];
    logic prev_hs;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference Alu expressed as plain integer arithmetic.
    function automatic logic [31:0] alu_ref(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_v, ua, ub, p, q;
        int unsigned sh;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        ua   = longint'({32'b0, a});
        ub   = longint'({32'b0, b});
        sh   = b % 32;
        p    = longint'(1) << sh;
        case (sel)
            OP_ADD:  return 32'(ua + ub);
            OP_SUB:  return 32'(ua - ub);
            OP_SLL:  return 32'(ua * p);
            OP_SRL:  return 32'(ua / p);
            OP_SRA: begin
                q = sa / p;
                if ((sa % p) != 0 && sa < 0) q = q - 1;
                return 32'(q);
            end
            OP_SLT:  return (sa < sb_v) ? 32'd1 : 32'd0;
            OP_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Response-side consumer: always ready, random, or held off per port.
    always @(posedge clk) begin
        #2;
        for (int p = 0; p < 2; p++) begin
            rrdy[p] = hold[p] ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: invariants, arbitration model and scoreboard pops.
    always @(negedge clk) begin
        int g, exp_g;
        if (!rst_n) begin
            seen[0] = 1'b0;
            seen[1] = 1'b0;
            prev_hs = 1'b0;
        end else begin
            chk("ready_exclusive", 32'(ready[0] && ready[1]), 32'd0);
            chk("rsp_valid_exclusive", 32'(rspv[0] && rspv[1]), 32'd0);
            chk("no_grant_during_rsp", 32'((ready[0] || ready[1]) && (rspv[0] || rspv[1])), 32'd0);
            if (prev_hs) begin
                chk("rsp_drop_after_accept", 32'(rspv[0] || rspv[1]), 32'd0);
                if (rv[0] || rv[1]) chk("idle_after_accept", 32'(ready[0] || ready[1]), 32'd1);
            end
            prev_hs = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (rspv[p]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: port %0d valid with empty scoreboard (cycle %0d)", p, cyc);
                    end else begin
                        chk("rsp_port", 32'(p), 32'(sb[0].port));
                        if (!seen[p]) begin
                            chk("rsp_latency", 32'(cyc - sb[0].acc_cyc), 32'd2);
                            seen[p] = 1'b1;
                            held[p] = rspd[p];
                        end else begin
                            chk("rsp_stable", rspd[p], held[p]);
                        end
                        if (rrdy[p]) begin
                            chk("rsp_data", rspd[p], sb[0].data);
                            void'(sb.pop_front());
                            seen[p] = 1'b0;
                            prev_hs = 1'b1;
                        end
                    end
                end
            end
            if (ready[0] || ready[1]) begin
                g = ready[1] ? 1 : 0;
`ifdef ALU_ARB_RR_EN
                if (rv[0] && rv[1]) exp_g = (mdl_last == 0) ? 1 : 0;
                else                exp_g = rv[0] ? 0 : 1;
`else
                exp_g = rv[0] ? 0 : 1;
`endif
                chk("grant_port", 32'(g), 32'(exp_g));
                chk("grant_has_valid", 32'(rv[g]), 32'd1);
                mdl_last = g;
            end
        end
    end

    task automatic issue(input int p, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int n;
        rv[p] = 1'b1;
        rsel[p] = sel;
        ra[p] = a;
        rb[p] = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready[p]) begin
                sb.push_back('{port: p, data: exp, acc_cyc: cyc});
                break;
            end
            n++;
            if (n > 300) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        rv[p] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req0_ready", 32'(ready[0]), 32'd0);
        chk("rst_req1_ready", 32'(ready[1]), 32'd0);
        chk("rst_rsp0_valid", 32'(rspv[0]), 32'd0);
        chk("rst_rsp1_valid", 32'(rspv[1]), 32'd0);
        chk("rst_rsp0_data", rspd[0], 32'd0);
        chk("rst_rsp1_data", rspd[1], 32'd0);
        sb.delete();
        mdl_last = 1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, gap;
        logic [3:0]  s0, s1;
        logic [31:0] a0, b0, a1, b1;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0; rsel[p] = '0; ra[p] = '0; rb[p] = '0;
            rrdy[p] = 1'b1; hold[p] = 1'b0; seen[p] = 1'b0; held[p] = '0;
        end
        rnd_ready = 1'b0;
        prev_hs = 1'b0;
        do_reset();

        // Single op with latency check
        issue(0, OP_ADD, 32'd5, 32'd7, 32'd12);
        drain();

        // Contending pairs
        do_reset();
        repeat (2) begin
            fork
                issue(0, OP_SUB, 32'd10, 32'd3, 32'd7);
                issue(1, OP_XOR, 32'hF0, 32'hFF, 32'h0F);
            join
            drain();
        end

        // Backpressure on port 1 while port 0 waits
        hold[1] = 1'b1;
        fork
            issue(1, OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977);
            begin repeat (3) @(posedge clk); #1; issue(0, OP_ADD, 32'd1, 32'd2, 32'd3); end
            begin repeat (9) @(posedge clk); #1; hold[1] = 1'b0; end
        join
        drain();

        // Shift mask and comparisons
        issue(0, OP_SLL, 32'd1, 32'h23, 32'h8);
        issue(1, OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1);
        issue(0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        drain();

        // Reset during EXEC, then during RESP
        issue(1, OP_ADD, 32'd3, 32'd4, 32'd7);
        do_reset();
        hold[0] = 1'b1;
        issue(0, OP_ADD, 32'd1, 32'd1, 32'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_reset();
        hold[0] = 1'b0;
        fork
            issue(0, OP_OR, 32'hA0, 32'h05, 32'hA5);
            issue(1, OP_AND, 32'hFF, 32'h3C, 32'h3C);
        join
        drain();

        // Wraparound and undefined op code
        issue(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue(1, 4'b1111, 32'h1234, 32'h5678, 32'd0);
        drain();

        // Randomized traffic
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 2);
            s0 = 4'($urandom_range(0, 15));
            s1 = 4'($urandom_range(0, 15));
            a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b0 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            a1 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b1 = ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom;
            case (mode)
                0: issue(0, s0, a0, b0, alu_ref(s0, a0, b0));
                1: issue(1, s1, a1, b1, alu_ref(s1, a1, b1));
                default: begin
                    fork
                        issue(0, s0, a0, b0, alu_ref(s0, a0, b0));
                        issue(1, s1, a1, b1, alu_ref(s1, a1, b1));
                    join
                end
            endcase
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
